// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sync_fifo write port in bursts; define FIFO_ARB_STATS_EN for per-producer accepted-word counters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick, cand;
  logic [BW-1:0] burst_q, burst_d;
  logic busy_q, busy_d, found, in_grant, valid_g, wr, end_burst;
  always_comb begin
    pick = last_q;
    found = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    in_grant = state_q == GRANT;
    valid_g = req_valid[grant_q];
    wr = in_grant && valid_g && !fifo_full;
    end_burst = in_grant && (!valid_g || (wr && burst_q == BW'(BURST_LEN - 1)));
    req_ready = (in_grant && !fifo_full) ? NUM_REQ'(1) << grant_q : '0;
    fifo_wr_en = wr;
    fifo_data_in = wr ? req_data[grant_q*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    state_d = in_grant ? (end_burst ? IDLE : GRANT) : (found ? GRANT : IDLE);
    grant_d = (!in_grant && found) ? pick : grant_q;
    last_d = end_burst ? grant_q : last_q;
    burst_d = !in_grant ? '0 : wr ? burst_q + 1'b1 : burst_q;
    busy_d = state_d == GRANT;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      burst_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      busy_q  <= busy_d;
    end
  end
  assign grant_id = grant_q;
  assign busy = busy_q;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++)
      stat_d[k] = (wr && grant_q == IW'(k) && stat_q[k] != 16'hFFFF) ? stat_q[k] + 16'd1 : stat_q[k];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++)
      stat_q[k] <= !n_rst ? 16'd0 : stat_d[k];
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_cnt[i*16 +: 16] = stat_q[i];
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with a depth-16 sync_fifo model; FIFO_ARB_STATS_EN adds the counter scenario
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic force_full = 1'b0;
  logic fifo_full;
  logic fifo_wr_en;
  logic [W-1:0] fifo_data_in;
  logic [IW-1:0] grant_id;
  logic busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_cnt;
`endif
  logic [W-1:0] mem [256];
  int wptr = 0;
  int rptr = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] obs, e;
  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(4)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id(grant_id),
    .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_cnt(stat_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      mem[wptr % 256] <= fifo_data_in;
      wptr <= wptr + 1;
    end
  end
  assign fifo_full = force_full | ((wptr - rptr) >= 16);
  assign obs = {busy, grant_id, fifo_wr_en, fifo_data_in, req_ready};
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    req_valid = '0;
    force_full = 1'b0;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    rptr = wptr;
  endtask
  task automatic test_reset;
    req_valid = '1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h want %h", obs, 16'h0);
    end
    n_rst = 1'b1;
    req_valid = '0;
    rptr = wptr;
  endtask
  task automatic test_single;
    do_reset();
    req_data = {8'd0, 8'd0, 8'd10, 8'd0};
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL single idle: got %h want %h", obs, 16'h0);
    end
    e = {1'b1, 2'd1, 1'b1, 8'd10, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single word %0d: got %h want %h", i, obs, e);
      end
    end
    step();
    e = {1'b0, 2'd1, 1'b0, 8'd0, 4'b0000};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL single bubble: got %h want %h", obs, e);
    end
    step();
    e = {1'b1, 2'd1, 1'b1, 8'd10, 4'b0010};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL single regrant: got %h want %h", obs, e);
    end
    req_valid = '0;
    #1;
    e = {1'b1, 2'd1, 1'b0, 8'd0, 4'b0010};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL single drop: got %h want %h", obs, e);
    end
    step();
    e = {1'b0, 2'd1, 1'b0, 8'd0, 4'b0000};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL single release: got %h want %h", obs, e);
    end
    n_cmp++;
    if (wptr - rptr !== 4) begin
      n_fail++;
      $display("FAIL single count: got %0d want 4", wptr - rptr);
    end
    while (rptr < wptr) begin
      n_cmp++;
      if (mem[rptr % 256] !== 8'd10) begin
        n_fail++;
        $display("FAIL single fifo[%0d]: got %h want %h", rptr, mem[rptr % 256], 8'd10);
      end
      rptr++;
    end
  endtask
  task automatic test_round_robin;
    do_reset();
    req_data = {8'd30, 8'd20, 8'd10, 8'd0};
    req_valid = '1;
    for (int b = 0; b < 4; b++) begin
      e = {1'b1, IW'(b), 1'b1, W'(b * 10), N'(1 << b)};
      for (int i = 0; i < 4; i++) begin
        step();
        n_cmp++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL rr burst %0d word %0d: got %h want %h", b, i, obs, e);
        end
      end
      step();
      e = {1'b0, IW'(b), 1'b0, 8'd0, 4'b0000};
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rr bubble %0d: got %h want %h", b, obs, e);
      end
    end
    step();
    e = {1'b1, 2'd0, 1'b0, 8'd0, 4'b0000};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rr wrap on full fifo: got %h want %h", obs, e);
    end
    req_valid = '0;
    n_cmp++;
    if (wptr - rptr !== 16) begin
      n_fail++;
      $display("FAIL rr count: got %0d want 16", wptr - rptr);
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (mem[rptr % 256] !== W'((k / 4) * 10)) begin
        n_fail++;
        $display("FAIL rr fifo[%0d]: got %h want %h", k, mem[rptr % 256], W'((k / 4) * 10));
      end
      rptr++;
    end
  endtask
  task automatic test_full_stall;
    do_reset();
    req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
    req_valid = 4'b0010;
    e = {1'b1, 2'd1, 1'b1, 8'hA5, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall pre %0d: got %h want %h", i, obs, e);
      end
    end
    force_full = 1'b1;
    #1;
    e = {1'b1, 2'd1, 1'b0, 8'h00, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall hold %0d: got %h want %h", i, obs, e);
      end
      step();
    end
    force_full = 1'b0;
    #1;
    e = {1'b1, 2'd1, 1'b1, 8'hA5, 4'b0010};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall resume: got %h want %h", obs, e);
    end
    step();
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall last word: got %h want %h", obs, e);
    end
    step();
    e = {1'b0, 2'd1, 1'b0, 8'h00, 4'b0000};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall end: got %h want %h", obs, e);
    end
    req_valid = '0;
    n_cmp++;
    if (wptr - rptr !== 4) begin
      n_fail++;
      $display("FAIL stall count: got %0d want 4", wptr - rptr);
    end
    while (rptr < wptr) begin
      n_cmp++;
      if (mem[rptr % 256] !== 8'hA5) begin
        n_fail++;
        $display("FAIL stall fifo[%0d]: got %h want %h", rptr, mem[rptr % 256], 8'hA5);
      end
      rptr++;
    end
  endtask
  task automatic test_early_drop;
    logic [W-1:0] want [2];
    want[0] = 8'h22;
    want[1] = 8'h33;
    do_reset();
    req_data = {8'h33, 8'h22, 8'h00, 8'h11};
    req_valid = 4'b0100;
    e = {1'b1, 2'd2, 1'b1, 8'h22, 4'b0100};
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drop grant2 %0d: got %h want %h", i, obs, e);
      end
    end
    req_valid = 4'b1001;
    #1;
    e = {1'b1, 2'd2, 1'b0, 8'h00, 4'b0100};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL drop no write: got %h want %h", obs, e);
    end
    step();
    e = {1'b0, 2'd2, 1'b0, 8'h00, 4'b0000};
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL drop idle: got %h want %h", obs, e);
    end
    e = {1'b1, 2'd3, 1'b1, 8'h33, 4'b1000};
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drop grant3 %0d: got %h want %h", i, obs, e);
      end
    end
    req_valid = '0;
    n_cmp++;
    if (wptr - rptr !== 2) begin
      n_fail++;
      $display("FAIL drop count: got %0d want 2", wptr - rptr);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (mem[rptr % 256] !== want[k]) begin
        n_fail++;
        $display("FAIL drop fifo[%0d]: got %h want %h", k, mem[rptr % 256], want[k]);
      end
      rptr++;
    end
  endtask
`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats;
    int base;
    int k;
    do_reset();
    base = wptr;
    k = 0;
    req_data = {8'd30, 8'd20, 8'd10, 8'd0};
    req_valid = '1;
    for (int c = 0; c < 200 && (wptr - base) < 64; c++) begin
      step();
      while (rptr < wptr) begin
        n_cmp++;
        if (mem[rptr % 256] !== W'(((k / 4) % 4) * 10)) begin
          n_fail++;
          $display("FAIL stats fifo[%0d]: got %h want %h", k, mem[rptr % 256], W'(((k / 4) % 4) * 10));
        end
        rptr++;
        k++;
      end
    end
    req_valid = '0;
    n_cmp++;
    if (wptr - base !== 64) begin
      n_fail++;
      $display("FAIL stats word budget: got %0d want 64", wptr - base);
    end
    #1;
    n_cmp++;
    if (stat_cnt !== {4{16'd16}}) begin
      n_fail++;
      $display("FAIL stats counts: got %h want %h", stat_cnt, {4{16'd16}});
    end
    dut.stat_q[0] = 16'hFFFF;
    req_valid = 4'b0001;
    repeat (2) step();
    req_valid = '0;
    #1;
    n_cmp++;
    if (stat_cnt !== {16'd16, 16'd16, 16'd16, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL stats saturate: got %h want %h", stat_cnt, {16'd16, 16'd16, 16'd16, 16'hFFFF});
    end
    rptr = wptr;
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_drop();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
